// File: rtl/fifo_rr_read_sched_pkg.sv
// Shared definitions for the FIFO read-side round-robin scheduler:
// FSM state codes, header LEN field position and default widths.
package fifo_rr_read_sched_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_TMO_W  = 6;

  // Payload word count sits in the low bits of the header word.
  localparam int HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_PLD  = 2'b10
  } state_t;

endpackage

// File: rtl/fifo_rr_read_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward
// from rr_ptr+1 with wrap-around. The pointer itself is never a candidate
// until all others have been examined, which gives it lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand_idx;
  int               cand_sum;

  // Scan N candidates starting just after the pointer; keep the first hit.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_idx = '0;
    cand_sum = 0;
    any      = |req;
    for (int k = 1; k <= N; k++) begin
      cand_sum = int'(rr_ptr) + k;
      if (cand_sum >= N) cand_sum = cand_sum - N;
      cand_idx = IDX_W'(cand_sum);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_read_sched.sv
// Read-side scheduler for one router output port. Grants one input FIFO
// at a time, streams a whole packet (header + LEN payload words) to a
// valid/ready link, then re-arbitrates round-robin. Pops are combinational
// on transfer; a stalled owner is dropped after 2**TMO_W-1 empty cycles.
module fifo_rr_read_sched
  import fifo_rr_read_sched_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TMO_W  = DEF_TMO_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        port_en,
  input  logic [N-1:0]        fifo_rempty,
  input  logic [N*DATA_W-1:0] fifo_rdata,
  output logic [N-1:0]        fifo_rinc,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic [N-1:0]        grant,
  output logic                err_tmo
);

  localparam int IDX_W = $clog2(N);
  // Value the stall counter holds on the last empty cycle before it would
  // reach all-ones; that cycle is the timeout.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   sel_reg, sel_next;
  logic [N-1:0]       grant_reg, grant_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic               err_tmo_reg, err_tmo_next;

  logic [N-1:0]       req;
  logic [N-1:0]       arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  logic [DATA_W-1:0]  word [N];
  logic [DATA_W-1:0]  head;
  logic [LEN_W-1:0]   hdr_len;
  logic               owned;
  logic               sel_empty;
  logic               xfer;
  logic               pkt_exit;

  assign req = port_en & ~fifo_rempty;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // Unpack FIFO head words and decode the per-FIFO pop strobe.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_port
      assign word[gi]      = fifo_rdata[gi*DATA_W +: DATA_W];
      assign fifo_rinc[gi] = xfer && (sel_reg == IDX_W'(gi));
    end
  endgenerate

  assign head      = word[sel_reg];
  assign hdr_len   = head[HDR_LEN_LSB +: LEN_W];
  assign owned     = (state_reg != ST_IDLE);
  assign sel_empty = fifo_rempty[sel_reg];
  assign out_valid = owned && !sel_empty;
  assign xfer      = out_valid && out_ready;
  assign out_data  = owned ? head : '0;
  assign out_sop   = (state_reg == ST_HDR);
  assign out_eop   = ((state_reg == ST_HDR) && (hdr_len == '0)) ||
                     ((state_reg == ST_PLD) && (beat_cnt_reg == LEN_W'(1)));
  assign grant     = grant_reg;
  assign err_tmo   = err_tmo_reg;

  // Packet FSM: arbitration, beat counting, stall timeout and release.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    err_tmo_next  = 1'b0;
    pkt_exit      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        tmo_cnt_next = '0;
        if (arb_any) begin
          state_next = ST_HDR;
          grant_next = arb_gnt;
          sel_next   = arb_idx;
        end
      end
      ST_HDR, ST_PLD: begin
        if (xfer) begin
          tmo_cnt_next = '0;
          if (state_reg == ST_HDR) begin
            beat_cnt_next = hdr_len;
            if (hdr_len == '0) pkt_exit = 1'b1;
            else               state_next = ST_PLD;
          end else begin
            beat_cnt_next = beat_cnt_reg - LEN_W'(1);
            if (beat_cnt_reg == LEN_W'(1)) pkt_exit = 1'b1;
          end
        end else if (sel_empty) begin
          if (tmo_cnt_reg == TMO_LAST) begin
            pkt_exit     = 1'b1;
            err_tmo_next = 1'b1;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (pkt_exit) begin
      state_next   = ST_IDLE;
      grant_next   = '0;
      rr_ptr_next  = sel_reg;
      tmo_cnt_next = '0;
    end
  end

  // State registers; reset leaves port 0 with first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      sel_reg      <= '0;
      grant_reg    <= '0;
      rr_ptr_reg   <= IDX_W'(N - 1);
      beat_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      err_tmo_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      err_tmo_reg  <= err_tmo_next;
    end
  end

endmodule

// File: tb/tb_fifo_rr_read_sched.sv
// Self-checking bench: FIFO models as queues, expected words pushed to a
// scoreboard when packets are loaded and popped on each link transfer.
module tb_fifo_rr_read_sched;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LW  = 4;
  localparam int TW  = 4;
  localparam int TMO_CYC = (2 ** TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  port_en;
  logic [N-1:0]  fifo_rempty;
  logic [N*DW-1:0] fifo_rdata;
  logic [N-1:0]  fifo_rinc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [N-1:0]  grant;
  logic          err_tmo;

  fifo_rr_read_sched #(.N(N), .DATA_W(DW), .LEN_W(LW), .TMO_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .port_en     (port_en),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .grant       (grant),
    .err_tmo     (err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        port;
    logic [7:0] data;
    bit        sop;
    bit        eop;
  } exp_t;

  typedef struct {
    int port;
    int len;
    int tag;
  } pkt_t;

  exp_t       sb[$];
  logic [7:0] fq[N][$];
  logic [N-1:0] stall_mask;

  int errors = 0;
  int checks = 0;
  int pops[N];
  int cyc;
  int ready_mode;
  int stall_port, stall_after, stall_len, stall_left;
  int en_clr_port, en_clr_after;
  int tmo_flush_port;
  int err_seen;
  int rinc_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int p, input int len, input int tag, input int n_exp);
    logic [7:0] w;
    exp_t e;
    for (int k = 0; k <= len; k++) begin
      w = (k == 0) ? 8'((tag << 4) | len) : 8'(tag * 17 + k);
      fq[p].push_back(w);
      if (n_exp < 0 || k < n_exp) begin
        e.port = p; e.data = w; e.sop = (k == 0); e.eop = (k == len);
        sb.push_back(e);
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      fifo_rempty[i] = (fq[i].size() == 0) || stall_mask[i];
      fifo_rdata[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
    end
  endtask

  task automatic reset_hooks();
    stall_port = -1; en_clr_port = -1; tmo_flush_port = -1;
    stall_left = 0; stall_mask = '0; err_seen = 0; rinc_count = 0; cyc = 0;
    for (int i = 0; i < N; i++) pops[i] = 0;
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic step();
    exp_t e;
    @(negedge clk);
    out_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    stall_mask = (stall_left > 0) ? N'(1 << stall_port) : '0;
    apply();
    #1;
    if (err_tmo) begin
      err_seen++;
      check("tmo_grant_zero", 32'(grant), 32'h0);
      if (tmo_flush_port >= 0) begin
        port_en[tmo_flush_port] = 1'b0;
        fq[tmo_flush_port].delete();
        apply();
        #1;
      end
    end
    if (stall_mask != '0) begin
      check("stall_valid", 32'(out_valid), 32'h0);
      check("stall_grant", 32'(grant), 32'(1 << stall_port));
    end
    if (ready_mode != 0 && !out_ready) check("bp_rinc", 32'(fifo_rinc), 32'h0);
    if (fifo_rinc != '0) rinc_count++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        $display("xfer t=%0t port=%0d data=%02h sop=%0b eop=%0b", $time, e.port, out_data, out_sop, out_eop);
        check("data", 32'(out_data), 32'(e.data));
        check("sop", 32'(out_sop), 32'(e.sop));
        check("eop", 32'(out_eop), 32'(e.eop));
        check("grant", 32'(grant), 32'(1 << e.port));
        check("rinc", 32'(fifo_rinc), 32'(1 << e.port));
        void'(fq[e.port].pop_front());
        pops[e.port]++;
        if (e.port == stall_port && pops[e.port] == stall_after) stall_left = stall_len + 1;
        if (e.port == en_clr_port && pops[e.port] == en_clr_after) port_en[e.port] = 1'b0;
      end
    end
    if (stall_left > 0) stall_left--;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 32'(sb.size()), 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  pkt_t fair_tab[12];

  initial begin
    // Fairness table: each FIFO holds three len-2 packets; expected service
    // order is the row order 0,1,2,3,0,1,2,3,...
    for (int r = 0; r < 12; r++) begin
      fair_tab[r].port = r % N;
      fair_tab[r].len  = 2;
      fair_tab[r].tag  = (r % 15) + 1;
    end

    ready_mode = 0;
    reset_hooks();
    out_ready = 1'b1;
    port_en   = '1;
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int r = 0; r < 12; r++) push_pkt(fair_tab[r].port, fair_tab[r].len, fair_tab[r].tag, -1);
    apply();
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_rinc", 32'(fifo_rinc), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_sop_eop", 32'({out_sop, out_eop}), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    @(posedge clk); #1;
    check("rst_grant_clk", 32'(grant), 32'h0);
    check("rst_err", 32'(err_tmo), 32'h0);
    rst = 1'b1;

    // Fairness: table-driven round-robin
    drain(400);
    idle(2);
    check("fair_no_tmo", 32'(err_seen), 32'h0);

    // Backpressure: len 3 with ready pattern 1,0,0
    reset_hooks();
    ready_mode = 1;
    push_pkt(0, 3, 5, -1);
    drain(100);
    ready_mode = 0;
    idle(2);
    check("bp_rinc_count", 32'(rinc_count), 32'd4);
    check("bp_no_tmo", 32'(err_seen), 32'h0);

    // FIFO empties after header + 2 payload words for 10 cycles
    reset_hooks();
    stall_port = 2; stall_after = 3; stall_len = 10;
    push_pkt(2, 4, 6, -1);
    drain(100);
    idle(2);
    check("stall_no_tmo", 32'(err_seen), 32'h0);

    // Timeout: owner stalls long enough; leftover words are abandoned and
    // the next grant goes to the port after the timed-out one.
    reset_hooks();
    stall_port = 1; stall_after = 2; stall_len = TMO_CYC; tmo_flush_port = 1;
    push_pkt(1, 4, 7, 2);
    push_pkt(2, 1, 8, -1);
    drain(200);
    idle(2);
    check("tmo_pulses", 32'(err_seen), 32'd1);
    port_en = '1;

    // Header-only packet, then owner's enable dropped mid-packet
    reset_hooks();
    push_pkt(1, 0, 9, -1);
    drain(50);
    idle(1);
    reset_hooks();
    en_clr_port = 1; en_clr_after = 1;
    push_pkt(1, 3, 10, -1);
    drain(50);
    idle(2);
    check("en_clr_no_tmo", 32'(err_seen), 32'h0);
    port_en = '1;

    // Asynchronous reset in the middle of a payload
    reset_hooks();
    push_pkt(0, 5, 11, 2);
    drain(50);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_rinc", 32'(fifo_rinc), 32'h0);
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_data", 32'(out_data), 32'h0);
    check("arst_sop_eop", 32'({out_sop, out_eop}), 32'h0);
    for (int i = 0; i < N; i++) fq[i].delete();
    reset_hooks();
    push_pkt(0, 1, 12, -1);
    push_pkt(3, 1, 13, -1);
    apply();
    @(negedge clk);
    rst = 1'b1;
    drain(50);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
